xor_frame_checker: RTL

- Receive-side checker for XOR-protected frames built from the 32-bit bitwise-XOR datapath.
- The sender streams N payload words followed by one checksum word, where the checksum is the XOR of all payload words.
- This block folds every received word into a running XOR accumulator and reports the final syndrome and a pass/fail flag.
- It sits between the ALU result bus and downstream consumers as the decode/check end of the XOR checksum link.

---
 rtl/xor_frame_checker.sv | 113 +++++++++++
 1 files changed

// File: rtl/xor_frame_checker.sv
// Receive-side checker for XOR-protected frames: folds N payload words plus one
// checksum word into a running XOR and reports the syndrome and a pass flag.
// Optional failed-frame counter enabled by defining XOR_FRAME_CHECKER_ERRCNT_EN.
module xor_frame_checker #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] syndrome,
  output logic [15:0]      err_count
);

  typedef enum logic [1:0] {StIdle, StPayload, StCheck, StReport} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] syn_q, syn_d;
  logic             pass_q, pass_d;
  logic             xfer;

  // Handshake and status are pure functions of state.
  always_comb begin
    in_ready = (state_q == StPayload) || (state_q == StCheck);
    busy     = (state_q != StIdle);
    done     = (state_q == StReport);
    xfer     = in_valid && in_ready;
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    syn_d   = syn_q;
    pass_d  = pass_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cnt_d   = len;
          acc_d   = '0;
          state_d = (len != '0) ? StPayload : StCheck;
        end
      end
      StPayload: begin
        if (xfer) begin
          acc_d = acc_q ^ in_data;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == LEN_W'(1)) state_d = StCheck;
        end
      end
      StCheck: begin
        if (xfer) begin
          syn_d   = acc_q ^ in_data;
          pass_d  = ((acc_q ^ in_data) == '0);
          state_d = StReport;
        end
      end
      StReport: begin
        // start is deliberately ignored here; the next frame begins from idle.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      syn_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      syn_q   <= syn_d;
      pass_q  <= pass_d;
    end
  end

  assign pass     = pass_q;
  assign syndrome = syn_q;

`ifdef XOR_FRAME_CHECKER_ERRCNT_EN
  logic [15:0] err_q;

  // Saturating count of frames reported as failed; pass_q already holds this frame's result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= '0;
    end else if ((state_q == StReport) && !pass_q && (err_q != 16'hFFFF)) begin
      err_q <= err_q + 16'd1;
    end
  end

  assign err_count = err_q;
`else
  assign err_count = 16'h0000;
`endif

endmodule
